// File: rtl/rv32i_types.sv
// Shared RV32I types.
//   rv32i_word   : 32-bit machine word (PCs, targets).
//   br_q_entry_t : one in-flight branch held by br_resolve_queue.
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  typedef struct packed {
    rv32i_word pc;
    logic      pred;
    logic      br_en;
    logic      resolved;
  } br_q_entry_t;

endpackage

// File: rtl/br_resolve_queue.sv
// Branch resolve queue. Holds each conditional branch from fetch-time
// prediction until execute-time resolution. It flags mispredicts with a
// redirect PC, and drains resolved branches in program order into the
// predictor update port.
//
// Ports
//   clk, rst_n                    clock, async active-low reset
//   alloc_valid/pc/pred           fetch allocation request
//   alloc_ready, alloc_tag        allocation handshake and assigned tag
//   resolve_valid/tag/br_en/target  execute resolution
//   mispredict, redirect_pc       one-cycle mispredict pulse and correct next PC
//   update, br_en, i_addr_update  one-cycle predictor update pulse (in order)
//   count                         occupied entries
module br_resolve_queue
  import rv32i_types::*;
#(
  parameter int DEPTH = 8,
  parameter int S_TAG = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc_valid,
  input  rv32i_word        alloc_pc,
  input  logic             alloc_pred,
  output logic             alloc_ready,
  output logic [S_TAG-1:0] alloc_tag,
  input  logic             resolve_valid,
  input  logic [S_TAG-1:0] resolve_tag,
  input  logic             resolve_br_en,
  input  rv32i_word        resolve_target,
  output logic             mispredict,
  output rv32i_word        redirect_pc,
  output logic             update,
  output logic             br_en,
  output rv32i_word        i_addr_update,
  output logic [S_TAG:0]   count
);

  localparam logic [S_TAG:0] PTR_ONE = 1;

  // Pointers carry one extra MSB as a wrap bit so full and empty differ.
  logic [S_TAG:0] head, tail;
  br_q_entry_t    q [DEPTH];

  logic             full, empty;
  logic [S_TAG-1:0] res_off;
  br_q_entry_t      res_entry, head_entry;
  logic             res_ok, res_mis, do_alloc, do_drain;

  always_comb begin
    count       = tail - head;
    empty       = (head == tail);
    full        = (head[S_TAG] != tail[S_TAG]) &&
                  (head[S_TAG-1:0] == tail[S_TAG-1:0]);
    // The registered mispredict blocks allocation for the cycle after a
    // squash, while fetch is still being redirected.
    alloc_ready = !full && !mispredict;
    alloc_tag   = tail[S_TAG-1:0];

    // The distance from head in modulo arithmetic places the tag inside or
    // outside the live window [head, tail).
    res_off     = resolve_tag - head[S_TAG-1:0];
    res_entry   = q[resolve_tag];
    res_ok      = resolve_valid && ({1'b0, res_off} < count) && !res_entry.resolved;
    res_mis     = res_ok && (resolve_br_en != res_entry.pred);
    // A same-cycle allocation is younger than any squashing branch, so it is
    // dropped.
    do_alloc    = alloc_valid && alloc_ready && !res_mis;

    head_entry  = q[head[S_TAG-1:0]];
    do_drain    = !empty && head_entry.resolved;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head          <= '0;
      tail          <= '0;
      mispredict    <= 1'b0;
      redirect_pc   <= '0;
      update        <= 1'b0;
      br_en         <= 1'b0;
      i_addr_update <= '0;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else begin
      if (do_alloc) begin
        q[tail[S_TAG-1:0]] <= '{pc: alloc_pc, pred: alloc_pred, br_en: 1'b0, resolved: 1'b0};
        tail <= tail + PTR_ONE;
      end

      if (res_ok) begin
        q[resolve_tag].br_en    <= resolve_br_en;
        q[resolve_tag].resolved <= 1'b1;
      end

      mispredict <= res_mis;
      if (res_mis) begin
        redirect_pc <= resolve_br_en ? resolve_target : res_entry.pc + 32'd4;
        // Compute the squash tail from the pre-edge head. This keeps the wrap
        // bit right even if head advances at this same edge.
        tail <= head + {1'b0, res_off} + PTR_ONE;
      end

      update <= do_drain;
      if (do_drain) begin
        br_en         <= head_entry.br_en;
        i_addr_update <= head_entry.pc;
        head          <= head + PTR_ONE;
      end
    end
  end

endmodule

// File: tb/tb_br_resolve_queue.sv
// Directed bench for br_resolve_queue. Inputs are driven and outputs are
// checked 1 ns after each rising edge.
module tb_br_resolve_queue;
  import rv32i_types::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alloc_valid;
  rv32i_word   alloc_pc;
  logic        alloc_pred;
  logic        alloc_ready;
  logic [2:0]  alloc_tag;
  logic        resolve_valid;
  logic [2:0]  resolve_tag;
  logic        resolve_br_en;
  rv32i_word   resolve_target;
  logic        mispredict;
  rv32i_word   redirect_pc;
  logic        update;
  logic        br_en;
  rv32i_word   i_addr_update;
  logic [3:0]  count;

  int tests = 0;
  int fails = 0;

  br_resolve_queue #(.DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_pc(alloc_pc), .alloc_pred(alloc_pred),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .resolve_valid(resolve_valid), .resolve_tag(resolve_tag),
    .resolve_br_en(resolve_br_en), .resolve_target(resolve_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .update(update), .br_en(br_en), .i_addr_update(i_addr_update),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", name, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic alloc(input rv32i_word pc, input logic pred);
    alloc_valid = 1'b1;
    alloc_pc    = pc;
    alloc_pred  = pred;
  endtask

  task automatic resolve(input logic [2:0] tag, input logic taken, input rv32i_word tgt);
    resolve_valid  = 1'b1;
    resolve_tag    = tag;
    resolve_br_en  = taken;
    resolve_target = tgt;
  endtask

  task automatic idle_in();
    alloc_valid   = 1'b0;
    resolve_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    alloc_valid = 1'b0; alloc_pc = '0; alloc_pred = 1'b0;
    resolve_valid = 1'b0; resolve_tag = '0; resolve_br_en = 1'b0; resolve_target = '0;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset, then idle.
    chk("rst_count", 32'(count), 0);
    chk("rst_ready", 32'(alloc_ready), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_update", 32'(update), 0);
      chk("idle_mispredict", 32'(mispredict), 0);
    end

    // Single branch, predicted correctly.
    alloc(32'h60, 1'b1);
    chk("t2_tag", 32'(alloc_tag), 0);
    tick();
    idle_in();
    chk("t2_count", 32'(count), 1);
    resolve(3'd0, 1'b1, 32'h999);
    tick();
    idle_in();
    chk("t2_no_misp", 32'(mispredict), 0);
    chk("t2_upd_early", 32'(update), 0);
    tick();
    chk("t2_update", 32'(update), 1);
    chk("t2_br_en", 32'(br_en), 1);
    chk("t2_addr", i_addr_update, 32'h60);
    chk("t2_count0", 32'(count), 0);
    tick();
    chk("t2_update_pulse", 32'(update), 0);

    // Mispredict squashes the younger entries.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      alloc(32'h100 + 32'(4 * i), 1'b0);
      chk("t3_tag", 32'(alloc_tag), 32'(i));
      tick();
    end
    idle_in();
    chk("t3_count4", 32'(count), 4);
    resolve(3'd1, 1'b1, 32'h200);
    tick();
    idle_in();
    chk("t3_misp", 32'(mispredict), 1);
    chk("t3_redirect", redirect_pc, 32'h200);
    chk("t3_count2", 32'(count), 2);
    chk("t3_ready_blk", 32'(alloc_ready), 0);
    tick();
    chk("t3_misp_pulse", 32'(mispredict), 0);
    chk("t3_ready", 32'(alloc_ready), 1);
    resolve(3'd2, 1'b1, 32'h300);
    tick();
    idle_in();
    chk("t3_tag2_ignored", 32'(mispredict), 0);
    chk("t3_count_keep", 32'(count), 2);
    resolve(3'd0, 1'b0, 32'h0);
    tick();
    idle_in();
    chk("t3_no_misp0", 32'(mispredict), 0);
    tick();
    chk("t3_upd0", 32'(update), 1);
    chk("t3_addr0", i_addr_update, 32'h100);
    chk("t3_br0", 32'(br_en), 0);
    tick();
    chk("t3_upd1", 32'(update), 1);
    chk("t3_addr1", i_addr_update, 32'h104);
    chk("t3_br1", 32'(br_en), 1);
    tick();
    chk("t3_upd_done", 32'(update), 0);
    chk("t3_empty", 32'(count), 0);

    // Not-taken mispredict with the fall-through PC wrapping at 32 bits.
    do_reset();
    alloc(32'hFFFF_FFFC, 1'b1);
    tick();
    idle_in();
    resolve(3'd0, 1'b0, 32'h1234);
    tick();
    idle_in();
    chk("t3b_misp", 32'(mispredict), 1);
    chk("t3b_redirect_wrap", redirect_pc, 32'h0);

    // Out-of-order resolution drains in program order.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      alloc(32'h100 + 32'(4 * i), 1'b0);
      tick();
    end
    idle_in();
    resolve(3'd2, 1'b0, 32'h0);
    tick();
    resolve(3'd1, 1'b0, 32'h0);
    tick();
    chk("t4_hold", 32'(update), 0);
    resolve(3'd0, 1'b0, 32'h0);
    tick();
    idle_in();
    chk("t4_hold2", 32'(update), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_upd", 32'(update), 1);
      chk("t4_order", i_addr_update, 32'h100 + 32'(4 * i));
    end
    tick();
    chk("t4_done", 32'(update), 0);
    chk("t4_empty", 32'(count), 0);

    // Full queue, then tag wrap.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      alloc(32'h400 + 32'(4 * i), 1'b0);
      chk("t5_tag", 32'(alloc_tag), 32'(i));
      tick();
      chk("t5_count", 32'(count), 32'(i + 1));
    end
    chk("t5_full_ready", 32'(alloc_ready), 0);
    chk("t5_full_tag", 32'(alloc_tag), 0);
    alloc(32'hDEAD, 1'b1);
    tick();
    idle_in();
    chk("t5_ignored", 32'(count), 8);
    resolve(3'd0, 1'b0, 32'h0);
    tick();
    idle_in();
    chk("t5_no_early_free", 32'(alloc_ready), 0);
    chk("t5_count8", 32'(count), 8);
    tick();
    chk("t5_drain", 32'(update), 1);
    chk("t5_drain_pc", i_addr_update, 32'h400);
    chk("t5_count7", 32'(count), 7);
    chk("t5_ready", 32'(alloc_ready), 1);
    chk("t5_wrap_tag", 32'(alloc_tag), 0);
    alloc(32'h500, 1'b1);
    tick();
    idle_in();
    chk("t5_refull", 32'(count), 8);
    chk("t5_refull_ready", 32'(alloc_ready), 0);
    // The wrapped entry is the youngest, so squashing at it keeps all eight.
    resolve(3'd0, 1'b0, 32'h0);
    tick();
    idle_in();
    chk("t5_wrap_misp", 32'(mispredict), 1);
    chk("t5_wrap_redirect", redirect_pc, 32'h504);
    chk("t5_wrap_count", 32'(count), 8);

    // Asynchronous reset while update is high.
    do_reset();
    alloc(32'h60, 1'b0);
    tick();
    alloc(32'h64, 1'b0);
    tick();
    idle_in();
    resolve(3'd0, 1'b0, 32'h0);
    tick();
    idle_in();
    tick();
    chk("t6_pre_update", 32'(update), 1);
    chk("t6_pre_count", 32'(count), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_update", 32'(update), 0);
    chk("t6_async_misp", 32'(mispredict), 0);
    chk("t6_async_count", 32'(count), 0);
    #1;
    rst_n = 1'b1;
    alloc(32'h80, 1'b1);
    chk("t6_tag0", 32'(alloc_tag), 0);
    chk("t6_ready", 32'(alloc_ready), 1);
    tick();
    idle_in();
    chk("t6_count1", 32'(count), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/br_resolve_queue.md
Name: br_resolve_queue

Overview:
- Tracks every conditional branch between its fetch-time prediction and its execute-time resolution.
- Fetch allocates an entry holding the PC and the predicted direction taken from the global-history predictor's `br_take`.
- Execute resolves entries by tag. The block flags mispredicts and produces the redirect PC.
- It drains resolved entries strictly in program order into the predictor's update port (`update`, `br_en`, `i_addr_update`). In-order draining keeps the predictor's global history register consistent with program order.

Parameters:
- DEPTH, 8, number of in-flight branch entries; power of 2, at least 2.
- S_TAG, $clog2(DEPTH), tag width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- alloc_valid  in  1  fetch records a predicted branch this cycle
- alloc_pc  in  32  branch PC (rv32i_word)
- alloc_pred  in  1  predicted direction, 1 = taken
- alloc_ready  out  1  queue can accept an allocation
- alloc_tag  out  S_TAG  tag assigned to an allocation made this cycle
- resolve_valid  in  1  execute resolves one branch this cycle
- resolve_tag  in  S_TAG  tag of the resolving branch
- resolve_br_en  in  1  actual outcome, 1 = taken
- resolve_target  in  32  actual taken target
- mispredict  out  1  one-cycle pulse: predicted direction was wrong
- redirect_pc  out  32  correct next PC, valid while mispredict = 1
- update  out  1  one-cycle pulse: predictor update
- br_en  out  1  outcome of the drained branch
- i_addr_update  out  32  PC of the drained branch
- count  out  S_TAG+1  number of occupied entries

Behaviour:
- Reset:
  - Asynchronous active-low; may assert at any time, including mid-operation.
  - Clears head and tail pointers, all entry valid/resolved bits, and every output register (mispredict, redirect_pc, update, br_en, i_addr_update = 0).
  - After reset: count = 0, alloc_ready = 1.
- Storage:
  - Circular buffer. Head and tail pointers are S_TAG+1 bits wide, with the MSB used as a wrap bit.
  - count = tail - head. Empty when the pointers are equal. Full when the MSBs differ and the low bits are equal.
  - Each entry holds pc, pred, br_en, resolved.
- Allocation:
  - alloc_ready = !full && !mispredict_pending. Combinational; a drain in the same cycle does not free a slot early.
  - alloc_tag = tail[S_TAG-1:0], combinational.
  - On alloc_valid && alloc_ready, the entry is written at the edge (resolved = 0) and tail increments.
  - alloc_valid with alloc_ready = 0 is ignored.
- Resolution:
  - A resolve is accepted only if the tag lies within [head, tail) and the entry is unresolved. Otherwise it is ignored silently.
  - On an accepted resolve, the entry's br_en is stored and resolved is set at the edge.
  - If resolve_br_en != pred: at the same edge, mispredict <= 1 and redirect_pc <= resolve_br_en ? resolve_target : pc+4 (32-bit wrap).
  - The squash also happens at that edge: tail is set to the position one past the resolved entry, with the wrap bit reconstructed from head. All younger entries are discarded.
  - An allocation in the same cycle as a mispredicting resolve is dropped and tail is not advanced for it.
  - mispredict_pending equals the registered mispredict, which blocks allocation for one cycle.
- Drain:
  - At each edge, if the head entry is resolved: pop it, set update <= 1, br_en <= entry.br_en, i_addr_update <= entry.pc, and advance head. Otherwise update <= 0.
  - At most one entry drains per cycle.
  - A resolve of the head entry at edge k drains at edge k+1, with no bypass.
  - Drain, allocate and resolve may all occur in the same cycle.
  - A squash never removes the resolving entry or anything older.
- Latency:
  - Mispredict is visible 1 cycle after the resolve edge.
  - Predictor update is visible 2 cycles after the resolve of the head entry.

Decomposition:
- rv32i_types:
  - Add the br_q_entry_t packed struct (pc, pred, br_en, resolved).
  - Reuse rv32i_word.
- Single module; no sub-module. Pointer and full/empty arithmetic stays local.

Test Plan:
- Reset then idle -> count = 0, alloc_ready = 1, update/mispredict never pulse.
- Allocate pc 0x60 (pred 1) at tag 0, resolve tag 0 br_en 1 -> no mispredict. Two cycles later update = 1, br_en = 1, i_addr_update = 0x60 for exactly one cycle.
- Allocate tags 0..3 (pc 0x100, 0x104, 0x108, 0x10C, all pred 0); resolve tag 1 br_en 1 target 0x200 -> mispredict = 1, redirect_pc = 0x200, count drops to 2, alloc_ready = 0 for one cycle. A later resolve of tag 2 is ignored.
- Resolve tag 2 before tag 0 (all correct predictions) -> no update until tag 0 resolves. Then updates occur in pc order 0x100, 0x104, 0x108 on consecutive cycles.
- Fill all 8 entries -> alloc_ready = 0, and a further alloc_valid is ignored. Drain one and refill -> tags wrap 7 -> 0, with count correct throughout.
- Assert rst_n low mid-drain with update = 1 -> update, mispredict and count go to 0 immediately and asynchronously. After release the queue accepts tag 0 again.
